// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Only one transaction is outstanding; a response timeout returns an error pulse.
module mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ready_o,
  output logic                if_resp_valid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_err_o,
  input  logic                ls_valid_i,
  input  logic                ls_wen_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wmask_i,
  output logic                ls_ready_o,
  output logic                ls_resp_valid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                ls_err_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic                mem_wen_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_resp_valid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_ls_q, owner_ls_d;
  logic                last_ls_q, last_ls_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_valid_q, req_valid_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                if_rv_q, if_rv_d, ls_rv_q, ls_rv_d;
  logic                if_err_q, if_err_d, ls_err_q, ls_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic                grant_if, grant_ls, timeout_hit;

  // On a tie, the requester that was not granted last wins.
  always_comb begin
    grant_ls    = ls_valid_i && (!if_valid_i || !last_ls_q);
    grant_if    = if_valid_i && !grant_ls;
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (if_valid_i || ls_valid_i) state_d = S_REQ;
      S_REQ:   if (mem_req_ready_i) state_d = S_RESP;
      S_RESP:  if (mem_resp_valid_i || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if_ready_o = !rst && (state_q == S_IDLE) && grant_if;
    ls_ready_o = !rst && (state_q == S_IDLE) && grant_ls;
  end

  always_comb begin
    owner_ls_d = owner_ls_q;
    last_ls_d  = last_ls_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    if_rv_d    = 1'b0;
    ls_rv_d    = 1'b0;
    if_err_d   = if_err_q;
    ls_err_d   = ls_err_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (if_valid_i || ls_valid_i) begin
          owner_ls_d = grant_ls;
          last_ls_d  = grant_ls;
          wen_d      = grant_ls ? ls_wen_i : 1'b0;
          addr_d     = grant_ls ? ls_addr_i : if_addr_i;
          wdata_d    = grant_ls ? ls_wdata_i : '0;
          wmask_d    = grant_ls ? ls_wmask_i : '0;
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) cnt_d = '0;
      end
      S_RESP: begin
        // A response in the timeout cycle still counts as a normal response.
        if (mem_resp_valid_i || timeout_hit) begin
          if (owner_ls_q) begin
            ls_rv_d    = 1'b1;
            ls_err_d   = !mem_resp_valid_i;
            ls_rdata_d = (mem_resp_valid_i && !wen_q) ? mem_rdata_i : '0;
          end else begin
            if_rv_d    = 1'b1;
            if_err_d   = !mem_resp_valid_i;
            if_rdata_d = mem_resp_valid_i ? mem_rdata_i : '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    req_valid_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_ls_q  <= 1'b0;
      last_ls_q   <= 1'b0;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      if_rv_q     <= 1'b0;
      ls_rv_q     <= 1'b0;
      if_err_q    <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      owner_ls_q  <= owner_ls_d;
      last_ls_q   <= last_ls_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      if_rv_q     <= if_rv_d;
      ls_rv_q     <= ls_rv_d;
      if_err_q    <= if_err_d;
      ls_err_q    <= ls_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign mem_req_valid_o = req_valid_q;
  assign mem_wen_o       = wen_q;
  assign mem_addr_o      = addr_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wmask_o     = wmask_q;
  assign if_resp_valid_o = if_rv_q;
  assign if_rdata_o      = if_rdata_q;
  assign if_err_o        = if_err_q;
  assign ls_resp_valid_o = ls_rv_q;
  assign ls_rdata_o      = ls_rdata_q;
  assign ls_err_o        = ls_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, ties, write, timeout, reset and fairness.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i, ls_valid_i, ls_wen_i;
  logic [63:0] if_addr_i, ls_addr_i, ls_wdata_i, mem_rdata_i;
  logic [7:0]  ls_wmask_i;
  logic        mem_req_ready_i, mem_resp_valid_i;
  logic        if_ready_o, if_resp_valid_o, if_err_o;
  logic        ls_ready_o, ls_resp_valid_o, ls_err_o;
  logic [63:0] if_rdata_o, ls_rdata_o, mem_addr_o, mem_wdata_o;
  logic        mem_req_valid_o, mem_wen_o;
  logic [7:0]  mem_wmask_o;

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
    .if_resp_valid_o(if_resp_valid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_valid_i(ls_valid_i), .ls_wen_i(ls_wen_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i), .ls_ready_o(ls_ready_o),
    .ls_resp_valid_o(ls_resp_valid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    #1;
    chk({tag, "_if_ready"}, if_ready_o, 0);
    chk({tag, "_ls_ready"}, ls_ready_o, 0);
    chk({tag, "_req_valid"}, mem_req_valid_o, 0);
    chk({tag, "_resp_valids"}, {if_resp_valid_o, ls_resp_valid_o, if_err_o, ls_err_o}, 0);
    chk({tag, "_if_rdata"}, if_rdata_o, 0);
    chk({tag, "_ls_rdata"}, ls_rdata_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_mem_wen_wmask"}, {mem_wen_o, mem_wmask_o}, 0);
  endtask

  // Called in the first REQ cycle; returns in the cycle the requester response pulses.
  task automatic downstream(input int rdy_wait, input int rsp_wait, input logic [63:0] rd);
    for (int i = 0; i < rdy_wait; i++) begin
      mem_req_ready_i = 1'b0;
      tick();
    end
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < rsp_wait; i++) tick();
    mem_resp_valid_i = 1'b1;
    mem_rdata_i      = rd;
    tick();
    mem_resp_valid_i = 1'b0;
    mem_rdata_i      = '0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic exp_ls;
    rst = 1'b1;
    if_valid_i = 0; ls_valid_i = 0; ls_wen_i = 0;
    if_addr_i = '0; ls_addr_i = '0; ls_wdata_i = '0; ls_wmask_i = '0;
    mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_rdata_i = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single IF read
    if_valid_i = 1'b1; if_addr_i = 64'h8000_0000;
    #1;
    chk("t1_if_ready", if_ready_o, 1);
    chk("t1_ls_ready", ls_ready_o, 0);
    tick();
    if_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    #1;
    chk("t1_req_valid", mem_req_valid_o, 1);
    chk("t1_req_addr", mem_addr_o, 64'h8000_0000);
    chk("t1_req_wen", mem_wen_o, 0);
    tick();
    mem_req_ready_i = 1'b0;
    chk("t1_req_drop", mem_req_valid_o, 0);
    tick();
    mem_resp_valid_i = 1'b1; mem_rdata_i = 64'h13;
    #1;
    chk("t1_no_early_resp", if_resp_valid_o, 0);
    tick();
    mem_resp_valid_i = 1'b0; mem_rdata_i = '0;
    chk("t1_resp_valid", if_resp_valid_o, 1);
    chk("t1_rdata", if_rdata_o, 64'h13);
    chk("t1_err", if_err_o, 0);
    chk("t1_ls_quiet", ls_resp_valid_o, 0);
    tick();
    chk("t1_pulse_end", if_resp_valid_o, 0);

    // Simultaneous requests from reset
    rst = 1'b1; tick(); rst = 1'b0;
    if_valid_i = 1'b1; if_addr_i = 64'h8000_0040;
    ls_valid_i = 1'b1; ls_wen_i = 1'b0; ls_addr_i = 64'h8000_2000;
    #1;
    chk("t2_tie1_ls", ls_ready_o, 1);
    chk("t2_tie1_if", if_ready_o, 0);
    tick();
    ls_valid_i = 1'b0;
    chk("t2_ls_addr", mem_addr_o, 64'h8000_2000);
    downstream(0, 0, 64'h55);
    chk("t2_ls_resp", ls_resp_valid_o, 1);
    chk("t2_ls_rdata", ls_rdata_o, 64'h55);
    chk("t2_if_grant_same_cycle", if_ready_o, 1);
    tick();
    if_valid_i = 1'b0;
    chk("t2_if_addr", mem_addr_o, 64'h8000_0040);
    downstream(0, 1, 64'h66);
    chk("t2_if_resp", if_resp_valid_o, 1);
    chk("t2_if_rdata", if_rdata_o, 64'h66);
    chk("t2_ls_quiet", ls_resp_valid_o, 0);
    if_valid_i = 1'b1; ls_valid_i = 1'b1;
    #1;
    chk("t2_tie2_ls", ls_ready_o, 1);
    chk("t2_tie2_if", if_ready_o, 0);
    tick();
    if_valid_i = 1'b0; ls_valid_i = 1'b0;
    downstream(1, 1, 64'h77);
    chk("t2_ls_resp2", ls_resp_valid_o, 1);

    // LS write with a stalled downstream
    ls_valid_i = 1'b1; ls_wen_i = 1'b1; ls_addr_i = 64'h8000_1000;
    ls_wdata_i = 64'h1122_3344_5566_7788; ls_wmask_i = 8'h0F;
    #1;
    chk("t3_ls_ready", ls_ready_o, 1);
    tick();
    ls_valid_i = 1'b0; ls_wen_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_wmask_i = '0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready_i = (i == 3);
      #1;
      chk("t3_req_valid", mem_req_valid_o, 1);
      chk("t3_addr", mem_addr_o, 64'h8000_1000);
      chk("t3_wdata", mem_wdata_o, 64'h1122_3344_5566_7788);
      chk("t3_wen_wmask", {mem_wen_o, mem_wmask_o}, 9'h10F);
      tick();
    end
    mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF;
    tick();
    mem_resp_valid_i = 1'b0; mem_rdata_i = '0;
    chk("t3_resp", ls_resp_valid_o, 1);
    chk("t3_rdata_zero", ls_rdata_o, 0);
    chk("t3_err", ls_err_o, 0);

    // Timeout with TIMEOUT=4
    tick();
    if_valid_i = 1'b1; if_addr_i = 64'h8000_0080;
    #1;
    chk("t4_if_ready", if_ready_o, 1);
    tick();
    if_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_no_resp_yet", if_resp_valid_o, 0);
      tick();
    end
    chk("t4_resp", if_resp_valid_o, 1);
    chk("t4_err", if_err_o, 1);
    chk("t4_rdata_zero", if_rdata_o, 0);
    tick();
    chk("t4_pulse_end", if_resp_valid_o, 0);
    mem_resp_valid_i = 1'b1; mem_rdata_i = 64'hBAD;
    tick();
    mem_resp_valid_i = 1'b0; mem_rdata_i = '0;
    chk("t4_late_ignored", {if_resp_valid_o, ls_resp_valid_o}, 0);
    chk("t4_still_idle", mem_req_valid_o, 0);

    // Reset while in RESP with LS as owner
    ls_valid_i = 1'b1; ls_addr_i = 64'h8000_3000;
    #1;
    chk("t5_ls_ready", ls_ready_o, 1);
    tick();
    ls_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("t5_after_rst");
    mem_resp_valid_i = 1'b1; mem_rdata_i = 64'h1234;
    tick();
    mem_resp_valid_i = 1'b0; mem_rdata_i = '0;
    chk("t5_late_ignored", {if_resp_valid_o, ls_resp_valid_o}, 0);
    tick();
    if_valid_i = 1'b1; ls_valid_i = 1'b1;
    #1;
    chk("t5_tie_ls", ls_ready_o, 1);
    chk("t5_tie_if", if_ready_o, 0);
    tick();
    downstream(0, 0, 64'h1);

    // Both valid continuously: grants must alternate, IF next
    exp_ls = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t6_rr_ls", ls_ready_o, exp_ls);
      chk("t6_rr_if", if_ready_o, !exp_ls);
      tick();
      downstream(0, 0, 64'(i));
      exp_ls = !exp_ls;
    end
    if_valid_i = 1'b0; ls_valid_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single memory port between the instruction-fetch requester (IF) and the load/store requester (LS) of the RV64 core. It replaces the per-stage direct DPI-C memory access once fetch and memory move to a shared bus. One transaction is outstanding at a time. Grant is round-robin, and a response timeout returns an error so the core never hangs.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; wmask width is DATA_W/8
- TIMEOUT, 255, maximum cycles in RESP before an error response; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_valid_i  in  1  IF request (read only)
- if_addr_i  in  ADDR_W  IF address
- if_ready_o  out  1  IF request accepted this cycle
- if_resp_valid_o  out  1  IF response, one-cycle pulse
- if_rdata_o  out  DATA_W  IF read data
- if_err_o  out  1  IF response is a timeout error
- ls_valid_i  in  1  LS request
- ls_wen_i  in  1  1 = write, 0 = read
- ls_addr_i  in  ADDR_W  LS address
- ls_wdata_i  in  DATA_W  LS write data
- ls_wmask_i  in  DATA_W/8  LS byte mask
- ls_ready_o  out  1  LS request accepted this cycle
- ls_resp_valid_o  out  1  LS response, one-cycle pulse
- ls_rdata_o  out  DATA_W  LS read data; 0 for writes
- ls_err_o  out  1  LS response is a timeout error
- mem_req_valid_o  out  1  downstream request
- mem_req_ready_i  in  1  downstream accepts the request
- mem_wen_o, mem_addr_o, mem_wdata_o, mem_wmask_o  out  1/ADDR_W/DATA_W/DATA_W/8  registered payload
- mem_resp_valid_i  in  1  downstream response
- mem_rdata_i  in  DATA_W  downstream read data

## Operation
- States: IDLE, REQ, RESP.
- **IDLE**
  - If any requester is valid, grant one requester.
  - Drive its `*_ready_o` combinationally this cycle.
  - Latch the payload and the owner (IF or LS), then go to REQ.
  - IF payload latches with wen=0, wdata=0, wmask=0.
- **Arbitration**
  - If only one requester is valid, it wins.
  - If both are valid, the one not granted last wins.
  - The last-grant pointer resets to IF, so LS wins the first tie.
- **REQ**
  - `mem_req_valid_o`=1 with a stable payload.
  - On `mem_req_ready_i`=1, go to RESP and clear the timeout counter.
- **RESP**
  - `mem_req_valid_o`=0.
  - On `mem_resp_valid_i`=1, register `mem_rdata_i` to the owner's rdata and pulse the owner's resp_valid the next cycle with err=0. Go to IDLE.
  - If the owner is an LS write, its rdata is 0.
- **Timeout**
  - The counter increments each cycle in RESP without a response.
  - When the counter equals TIMEOUT-1 and there is no response, pulse the owner's resp_valid with rdata=0 and err=1, then go to IDLE.
  - A response arriving in the same cycle as the timeout wins, with err=0.
  - A `mem_resp_valid_i` seen in IDLE or REQ is ignored.
- **Requester contract**
  - A requester holds valid and payload stable until it sees ready.
  - The arbiter never withdraws a grant.
- The non-owner's resp_valid is always 0.
- **Reset** (any state, including mid-transaction)
  - State returns to IDLE and the pointer to IF.
  - All outputs go to 0.
  - An in-flight downstream transaction is abandoned, and its late response is ignored.

## Timing
- **Grant latency:** ready is asserted in the same cycle as valid when the arbiter is in IDLE.
- **Request:** `mem_req_valid_o` rises 1 cycle after grant.
- **Response:** the requester's resp_valid comes 1 cycle after `mem_resp_valid_i`.
- **Minimum transaction**, with ready and response each returned in the same cycle they are first possible:
  - Grant at cycle N.
  - REQ with ready at N+1.
  - Response at N+2.
  - Requester resp_valid at N+3, which is also the earliest next grant.
- **Back-to-back:** the next grant occurs in the cycle the previous resp_valid pulses, because that cycle is IDLE.
- **Registered outputs:** all outputs except `*_ready_o` are registered.
- **Reset values:**
  - All valid, ready and err outputs are 0.
  - rdata and mem payload are 0.

## Test plan
- **Single IF read:** IF valid, addr=0x80000000; downstream ready immediately, resp 2 cycles later with rdata=0x00000013. Required:
  - `if_ready_o` in cycle 0.
  - `mem_req_valid_o` in cycle 1 with addr 0x80000000 and wen=0.
  - `if_resp_valid_o`=1, `if_rdata_o`=0x13, `if_err_o`=0 exactly 1 cycle after the downstream response.
- **Simultaneous requests:** IF and LS are valid together from reset, held until ready. Required:
  - LS is granted first and IF second, with no cycle idle between IF's grant and LS's response.
  - A further tie is won by LS again.
- **LS write:** addr=0x80001000, wdata=0x1122334455667788, wmask=0x0F, with `mem_req_ready_i` held 0 for 3 cycles. Required:
  - The payload is stable on the mem port for all 4 REQ cycles.
  - `ls_resp_valid_o` arrives with rdata=0.
- **Timeout:** TIMEOUT=4 and no downstream response. Required:
  - The owner's resp_valid pulses with err=1 and rdata=0 on the 4th RESP cycle.
  - A late `mem_resp_valid_i` produces no response pulse.
- **Reset in RESP:** rst=1 for 1 cycle during RESP. Required:
  - All outputs are 0 the next cycle.
  - A following downstream response is ignored.
  - The next tie grants LS.
- **Starvation check:** IF and LS are valid continuously for 20 transactions. Required: grants strictly alternate.
